mmio_uart_tx: RTL and testbench



---
 rtl/mmio_uart_pkg.sv | 32 +++
 rtl/mmio_uart_tx_fifo.sv | 55 +++++
 rtl/mmio_uart_tx.sv | 201 ++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register
// offsets, STATUS bit positions and the TX state encoding.
// Optional build macro: MMIO_UART_PARITY_EN (adds an even-parity bit).
package mmio_uart_pkg;

  // Word offsets inside the 16-byte register window (adr[3:2])
  localparam logic [1:0] OFF_TXDATA  = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;
  localparam logic [1:0] OFF_BAUDDIV = 2'd2;

  // STATUS register layout
  localparam int ST_BUSY_BIT  = 0;
  localparam int ST_FULL_BIT  = 1;
  localparam int ST_EMPTY_BIT = 2;
  localparam int ST_OVF_BIT   = 3;
  localparam int ST_CNT_LSB   = 4;

  // Three bits so the optional PARITY state fits without re-encoding
  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  // A divisor of zero would never advance the bit counter; run it as 1
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Synchronous FIFO for the TX path. Push while full and pop while empty are
// ignored; full is judged on the registered count, before any same-cycle pop.
module uart_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          din_i,
  input  logic                       pop_i,
  output logic [DATA_W-1:0]          dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              push_ok, pop_ok;

  assign full_o   = (count_q == CW'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign count_o  = count_q;
  assign push_ok  = push_i & ~full_o;
  assign pop_ok   = pop_i & ~empty_o;
  assign dout_o   = mem_q[rd_ptr_q];

  // Storage array: data only, no reset needed
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter for the multicycle MIPS data port.
// Register window at BASE_ADDR: TXDATA, STATUS, BAUDDIV. Bytes are queued in
// a small FIFO and shifted out on txd as 8N1 frames (8E1 when the build macro
// MMIO_UART_PARITY_EN is defined). txd is registered, so it trails the FSM
// state by one cycle.
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF_0000,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] adr,
  input  logic [31:0] writedata,
  input  logic        memwrite,
  output logic [31:0] readdata,
  output logic        hit,
  output logic        txd,
  output logic        busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]    off;
  logic          wr_tx, wr_status, wr_div;
  logic          fifo_full, fifo_empty, pop;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic [3:0]    cnt_field;
  logic          unused_bits;

  tx_state_e     state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   div_lat_q, div_lat_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic          txd_q, txd_d;
  logic [15:0]   div_q, div_d;
  logic          ovf_q, ovf_d;
  logic          bit_done;
  logic [15:0]   reload;

  assign hit         = (adr[31:4] == BASE_ADDR[31:4]);
  assign off         = adr[3:2];
  assign wr_tx       = memwrite & hit & (off == OFF_TXDATA);
  assign wr_status   = memwrite & hit & (off == OFF_STATUS);
  assign wr_div      = memwrite & hit & (off == OFF_BAUDDIV);
  assign busy        = (state_q != TX_IDLE);
  assign txd         = txd_q;
  assign cnt_field   = 4'(fifo_count);
  assign bit_done    = (cnt_q == 16'd0);
  assign reload      = div_lat_q - 16'd1;
  assign unused_bits = ^{adr[1:0], writedata[31:16]};

  uart_fifo #(
    .DATA_W (8),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (wr_tx),
    .din_i   (writedata[7:0]),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Register read mux: purely combinational from the address, no side effects
  always_comb begin
    readdata = '0;
    if (hit) begin
      case (off)
        OFF_STATUS: begin
          readdata[ST_BUSY_BIT]          = busy;
          readdata[ST_FULL_BIT]          = fifo_full;
          readdata[ST_EMPTY_BIT]         = fifo_empty;
          readdata[ST_OVF_BIT]           = ovf_q;
          readdata[ST_CNT_LSB +: 4]      = cnt_field;
        end
        OFF_BAUDDIV: readdata[15:0] = div_q;
        default:     readdata = '0;
      endcase
    end
  end

  // Next value of the software-visible divisor and sticky overflow flag
  always_comb begin
    div_d = div_q;
    ovf_d = ovf_q;
    if (wr_div) div_d = writedata[15:0];
    if (wr_status && writedata[ST_OVF_BIT]) ovf_d = 1'b0;
    if (wr_tx && fifo_full) ovf_d = 1'b1;
  end

  // Software-visible control registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= DEFAULT_DIV;
      ovf_q <= 1'b0;
    end else begin
      div_q <= div_d;
      ovf_q <= ovf_d;
    end
  end

  // TX FSM: next state, bit timing and the line level for the current state
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_lat_d = div_lat_q;
    idx_d     = idx_q;
    sh_d      = sh_q;
    pop       = 1'b0;
    txd_d     = 1'b1;
    case (state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          sh_d      = fifo_dout;
          div_lat_d = eff_div(div_q);
          cnt_d     = eff_div(div_q) - 16'd1;
          idx_d     = 3'd0;
          state_d   = TX_START;
        end
      end
      TX_START: begin
        txd_d = 1'b0;
        if (bit_done) begin
          cnt_d   = reload;
          idx_d   = 3'd0;
          state_d = TX_DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      TX_DATA: begin
        txd_d = sh_q[idx_q];
        if (bit_done) begin
          cnt_d = reload;
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
            state_d = TX_PARITY;
`else
            state_d = TX_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
`ifdef MMIO_UART_PARITY_EN
      TX_PARITY: begin
        txd_d = ^sh_q;
        if (bit_done) begin
          cnt_d   = reload;
          state_d = TX_STOP;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
`endif
      TX_STOP: begin
        txd_d = 1'b1;
        if (bit_done) begin
          state_d = TX_IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // TX FSM control registers and the registered serial output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= TX_IDLE;
      cnt_q     <= '0;
      div_lat_q <= '0;
      idx_q     <= '0;
      txd_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_lat_q <= div_lat_d;
      idx_q     <= idx_d;
      txd_q     <= txd_d;
    end
  end

  // Shift byte: data only, loaded at frame start
  always_ff @(posedge clk) begin
    sh_q <= sh_d;
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: table-driven register accesses,
// hand-written corner sequences and randomized frames against a waveform model.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
`ifdef MMIO_UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] adr;
  logic [31:0] writedata;
  logic        memwrite;
  logic [31:0] readdata;
  logic        hit;
  logic        txd;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mmio_uart_tx #(
    .BASE_ADDR   (BASE),
    .FIFO_DEPTH  (4),
    .DEFAULT_DIV (16'd434)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .adr       (adr),
    .writedata (writedata),
    .memwrite  (memwrite),
    .readdata  (readdata),
    .hit       (hit),
    .txd       (txd),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        do_wr;
    logic [31:0] wr_adr;
    logic [31:0] wr_data;
    logic [31:0] rd_adr;
    logic        exp_hit;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One store cycle: inputs set at a falling edge, captured by the next rising edge
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    adr = a; writedata = d; memwrite = 1'b1;
    @(negedge clk);
    memwrite = 1'b0; adr = 32'h0; writedata = 32'h0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    adr = a;
    #1;
    d = readdata;
  endtask

  // Reference line level for bit k of a frame carrying byte b
  function automatic logic exp_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (NB == 11 && k == 9) return ^b;
    return 1'b1;
  endfunction

  // Single frame from idle: whole txd waveform and busy duration against the model
  task automatic run_single(input logic [7:0] b, input logic [15:0] div);
    int d, len, bad, nbusy, first_bad;
    logic et;
    logic [31:0] st;
    d = (div == 16'd0) ? 1 : int'(div);
    len = NB * d;
    bad = 0; nbusy = 0; first_bad = -1;
    wr(BASE + 32'h8, {16'h0, div});
    wr(BASE, {24'h0, b});
    for (int i = 0; i < len + 8; i++) begin
      if (i < 2) et = 1'b1;
      else if (i - 2 < len) et = exp_bit(b, (i - 2) / d);
      else et = 1'b1;
      if (txd !== et) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
      if (busy === 1'b1) nbusy++;
      @(negedge clk);
    end
    if (bad != 0) $display("  byte 0x%0h div %0d: first wrong cycle %0d", b, div, first_bad);
    check("txd_wave_bad_cycles", bad, 0);
    check("busy_cycles", nbusy, len);
    rd(BASE + 32'h4, st);
    check("status_after_frame", st, 32'h4);
  endtask

  // Frame receiver: wait for a start bit, sample each bit at its centre
  task automatic recv(input int d, output logic [7:0] b, output bit ok);
    int t;
    t = 0; ok = 1'b1; b = 8'h0;
    while (txd !== 1'b0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) begin
      ok = 1'b0;
      return;
    end
    repeat (d / 2) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      repeat (d) @(negedge clk);
      b[k] = txd;
    end
    repeat (NB - 9) repeat (d) @(negedge clk);
  endtask

  initial begin
    logic [31:0] r;
    logic [7:0]  rb;
    bit          ok;
    int          t;

    reset = 1'b1; adr = 32'h0; writedata = 32'h0; memwrite = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_txd", {31'h0, txd}, 32'h1);
    check("reset_busy", {31'h0, busy}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Register map table
    vecs[0]  = '{1'b0, 32'h0,         32'h0,         BASE + 32'h4,  1'b1, 32'h4};
    vecs[1]  = '{1'b0, 32'h0,         32'h0,         BASE + 32'h8,  1'b1, 32'd434};
    vecs[2]  = '{1'b0, 32'h0,         32'h0,         BASE,          1'b1, 32'h0};
    vecs[3]  = '{1'b1, BASE + 32'h8,  32'hABCD_1234, BASE + 32'h8,  1'b1, 32'h1234};
    vecs[4]  = '{1'b1, BASE + 32'hC,  32'hFFFF_FFFF, BASE + 32'hC,  1'b1, 32'h0};
    vecs[5]  = '{1'b0, 32'h0,         32'h0,         BASE + 32'h8,  1'b1, 32'h1234};
    vecs[6]  = '{1'b1, BASE + 32'h10, 32'h55,        BASE + 32'h10, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 32'h0,         32'h0,         BASE + 32'h4,  1'b1, 32'h4};
    vecs[8]  = '{1'b0, 32'h0,         32'h0,         BASE + 32'hA,  1'b1, 32'h1234};
    vecs[9]  = '{1'b0, 32'h0,         32'h0,         BASE - 32'h4,  1'b0, 32'h0};
    vecs[10] = '{1'b1, BASE + 32'h4,  32'hFFFF_FFF7, BASE + 32'h4,  1'b1, 32'h4};
    vecs[11] = '{1'b1, BASE + 32'hB,  32'h0000_0004, BASE + 32'h8,  1'b1, 32'h4};
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].do_wr) wr(vecs[i].wr_adr, vecs[i].wr_data);
      rd(vecs[i].rd_adr, r);
      check($sformatf("vec%0d_hit", i), {31'h0, hit}, {31'h0, vecs[i].exp_hit});
      check($sformatf("vec%0d_rd", i), r, vecs[i].exp_rd);
    end
    check("idle_txd_after_table", {31'h0, txd}, 32'h1);

    // Latency to start bit, 0x55 at div 4
    wr(BASE + 32'h8, 32'd4);
    wr(BASE, 32'h55);
    check("lat_edge1_txd", {31'h0, txd}, 32'h1);
    @(negedge clk);
    check("lat_edge2_txd", {31'h0, txd}, 32'h1);
    @(negedge clk);
    check("lat_start_txd", {31'h0, txd}, 32'h0);
    repeat (NB * 4 + 4) @(negedge clk);

    // Full waveform checks, fixed and randomized
    run_single(8'h55, 16'd4);
    run_single(8'hFF, 16'd0);
    run_single(8'h07, 16'd0);
    for (int i = 0; i < 8; i++)
      run_single(8'($urandom), 16'($urandom_range(0, 5)));

    // Burst of six writes into a 4-deep FIFO while the first byte shifts
    wr(BASE + 32'h8, 32'd16);
    fork
      begin
        @(negedge clk);
        adr = BASE; memwrite = 1'b1;
        for (int i = 0; i < 6; i++) begin
          writedata = 32'h41 + 32'(i);
          @(negedge clk);
        end
        memwrite = 1'b0;
        rd(BASE + 32'h4, r);
        check("burst_status", r, 32'h4B);
        wr(BASE + 32'h4, 32'h8);
        rd(BASE + 32'h4, r);
        check("ovf_w1c_status", r, 32'h43);
        adr = 32'h0;
      end
      begin
        for (int i = 0; i < 5; i++) begin
          recv(16, rb, ok);
          if (!ok) begin
            checks++; errors++;
            $display("FAIL burst_frame%0d: no start bit within 5000 cycles", i);
          end else begin
            check($sformatf("burst_frame%0d", i), {24'h0, rb}, 32'h41 + 32'(i));
          end
        end
      end
    join
    t = 0;
    while (busy === 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    rd(BASE + 32'h4, r);
    check("burst_drained_status", r, 32'h4);

    // Asynchronous reset in the middle of a frame
    wr(BASE, 32'hA5);
    repeat (80) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midreset_txd", {31'h0, txd}, 32'h1);
    check("midreset_busy", {31'h0, busy}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rd(BASE + 32'h4, r);
    check("postreset_status", r, 32'h4);
    rd(BASE + 32'h8, r);
    check("postreset_bauddiv", r, 32'd434);
    repeat (5) @(negedge clk);
    check("postreset_idle_busy", {31'h0, busy}, 32'h0);
    check("postreset_idle_txd", {31'h0, txd}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
